branch_pc_unit: RTL

- ID-stage next-PC and redirect control for the 5-stage MIPS pipeline.
- Consumes the branch comparator's IDCompare/CompareOp plus jump decode.
- Owns the architectural PC register and drives the IF/ID write-enable and flush.
- Keeps branch statistics counters for ILA debug.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/branch_target_calc.sv | 46 ++++
 rtl/branch_pc_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: branch comparator op encodings, branch/PC FSM states, reset PC.
package pipeline_pkg;

  typedef enum logic [2:0] {
    CMP_NONE = 3'd0,
    CMP_BGEZ = 3'd1,
    CMP_BEQ  = 3'd2,
    CMP_BNE  = 3'd3,
    CMP_BGTZ = 3'd4,
    CMP_BLEZ = 3'd5,
    CMP_BLTZ = 3'd6
  } cmp_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational control-transfer select for the ID stage: priority JR > J > taken branch.
// Produces the target address and whether any transfer is requested (state/stall gating is in the top).
module branch_target_calc
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [2:0]          compare_op,
  input  logic                id_compare,
  input  logic                jump,
  input  logic                jump_reg,
  input  logic [PC_WIDTH-1:0] id_pc4,
  input  logic [31:0]         imm_offset,
  input  logic [25:0]         jump_index,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic                take,
  output logic [PC_WIDTH-1:0] target
);

  logic [PC_WIDTH-1:0] branch_off;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic                branch_taken;

  // Sign-extend to PC width before scaling; the add wraps modulo 2^PC_WIDTH.
  assign branch_off    = PC_WIDTH'($signed(imm_offset)) << 2;
  assign branch_target = id_pc4 + branch_off;
  assign jump_target   = {id_pc4[PC_WIDTH-1:28], jump_index, 2'b00};
  assign branch_taken  = (compare_op != CMP_NONE) && id_compare;

  always_comb begin
    take   = 1'b0;
    target = '0;
    if (jump_reg) begin
      take   = 1'b1;
      target = reg_target;
    end else if (jump) begin
      take   = 1'b1;
      target = jump_target;
    end else if (branch_taken) begin
      take   = 1'b1;
      target = branch_target;
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// ID-stage PC register, redirect/flush control and saturating branch statistics.
// BRANCH_DELAY_SLOT_EN: delay-slot mode, no IF/ID flush and the SQUASH state is never entered.
module branch_pc_unit
  import pipeline_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [2:0]           CompareOp,
  input  logic                 IDCompare,
  input  logic                 Jump,
  input  logic                 JumpReg,
  input  logic [PC_WIDTH-1:0]  IDPC4,
  input  logic [31:0]          ImmOffset,
  input  logic [25:0]          JumpIndex,
  input  logic [PC_WIDTH-1:0]  RegTarget,
  input  logic                 Stall,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 Redirect,
  output logic [CNT_WIDTH-1:0] TakenCount,
  output logic [CNT_WIDTH-1:0] BranchCount
);

  pc_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;

  logic                ctrl_take;
  logic [PC_WIDTH-1:0] ctrl_target;
  logic                evaluate;

  branch_target_calc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_target_calc (
    .compare_op (CompareOp),
    .id_compare (IDCompare),
    .jump       (Jump),
    .jump_reg   (JumpReg),
    .id_pc4     (IDPC4),
    .imm_offset (ImmOffset),
    .jump_index (JumpIndex),
    .reg_target (RegTarget),
    .take       (ctrl_take),
    .target     (ctrl_target)
  );

  // ID contents are only trusted in RUN; in SQUASH they are a flushed bubble.
  assign evaluate  = (state_q == ST_RUN) && !Stall;
  assign Redirect  = evaluate && ctrl_take;
  assign IFIDWrite = !Stall;
`ifdef BRANCH_DELAY_SLOT_EN
  assign IFIDFlush = 1'b0;
`else
  assign IFIDFlush = Redirect;
`endif

  assign PC          = pc_q;
  assign TakenCount  = taken_cnt_q;
  assign BranchCount = branch_cnt_q;

  always_comb begin
    pc_d         = pc_q;
    state_d      = state_q;
    taken_cnt_d  = taken_cnt_q;
    branch_cnt_d = branch_cnt_q;

    if (!Stall) begin
      pc_d = Redirect ? ctrl_target : pc_q + PC_WIDTH'(4);
    end

    case (state_q)
      ST_RUN: begin
`ifndef BRANCH_DELAY_SLOT_EN
        if (Redirect) state_d = ST_SQUASH;
`endif
      end
      ST_SQUASH: begin
        if (!Stall) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (Redirect && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
    end
    if (evaluate && (CompareOp != CMP_NONE) && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      state_q      <= ST_RUN;
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      taken_cnt_q  <= taken_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

endmodule
